// File: rtl/serial_adder.sv
// Digit-serial add/subtract: DIGIT bits per cycle, result after WIDTH/DIGIT cycles in RUN.
// No backpressure; start is ignored while busy, and held start in DONE chains the next operation.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STEPS = (DIGIT >= 1) ? WIDTH / DIGIT : 1;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    generate
        if (DIGIT < 1) begin : g_bad_digit
            $error("serial_adder: DIGIT must be >= 1");
        end else if (WIDTH % DIGIT != 0) begin : g_bad_width
            $error("serial_adder: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_reg, b_reg, acc, acc_nxt;
    logic             carry;
    logic [CW-1:0]    step;
    logic [31:0]      base;
    logic [DIGIT-1:0] a_slice, b_slice;
    logic [DIGIT:0]   slice_sum;
    logic             accept, last;

    always_comb begin
        base      = 32'(step) * DIGIT;
        a_slice   = a_reg[base +: DIGIT];
        b_slice   = b_reg[base +: DIGIT];
        slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{DIGIT{1'b0}}, carry};
        acc_nxt   = acc;
        acc_nxt[base +: DIGIT] = slice_sum[DIGIT-1:0];
        last      = (step == LAST);
        accept    = start && (state != RUN);
        busy      = (state == RUN);
        done      = (state == DONE);
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            carry <= 1'b0;
            step  <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_reg <= a;
                b_reg <= sub ? ~b : b;
                carry <= sub ? 1'b1 : cin;
                step  <= '0;
            end else if (state == RUN) begin
                acc   <= acc_nxt;
                carry <= slice_sum[DIGIT];
                step  <= step + 1'b1;
                // Carry into the MSB is recovered from the MSB's own sum bit and operands.
                if (last) begin
                    sum  <= acc_nxt;
                    cout <= slice_sum[DIGIT];
                    ovf  <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ acc_nxt[WIDTH-1] ^ slice_sum[DIGIT];
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Randomized scoreboard bench for serial_adder (WIDTH=8, DIGIT=2).
module tb_serial_adder;

    localparam int W = 8;
    localparam int D = 2;
    localparam int STEPS = W / D;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;

    serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin),
        .a(a), .b(b), .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    logic [W-1:0] prev_sum = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic, signed range test for overflow.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic msub, input logic mcin, input int done_cyc);
        exp_t   e;
        int     sa, sb_i, r;
        logic [W:0] u;
        sa   = $signed(ma);
        sb_i = $signed(mb);
        if (msub) begin
            e.sum  = ma - mb;
            e.cout = (ma >= mb);
            r      = sa - sb_i;
        end else begin
            u      = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mcin};
            e.sum  = u[W-1:0];
            e.cout = u[W];
            r      = sa + sb_i + int'(mcin);
        end
        e.ovf = (r > 127) || (r < -128);
        e.cyc = done_cyc;
        return e;
    endfunction

    // Monitor: pops on every done pulse; also flags sum moving outside a completion.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(sum), 32'hDEAD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sum", 32'(sum), 32'(e.sum));
                check("cout", 32'(cout), 32'(e.cout));
                check("ovf", 32'(ovf), 32'(e.ovf));
                check("done_cycle", 32'(cyc), 32'(e.cyc));
                check("busy_in_done", 32'(busy), 32'd0);
            end
        end
        if (rst_n && !done && sum !== prev_sum)
            check("sum_held", 32'(sum), 32'(prev_sum));
        prev_sum = sum;
    end

    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tsub,
                            input logic tcin, input bit immediate);
        if (!immediate) begin
            @(negedge clk);
            #1;
        end
        a = ta; b = tb_; sub = tsub; cin = tcin; start = 1'b1;
        sb.push_back(model(ta, tb_, tsub, tcin, cyc + 1 + STEPS));
    endtask

    // Runs until done; inputs are scrambled every cycle, start re-pulsed at iteration inject.
    task automatic wait_done(input int inject, output int busy_cnt);
        bit seen;
        busy_cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            seen = done;
            #1;
            start = (i == inject);
            a = W'($urandom); b = W'($urandom);
            sub = 1'($urandom); cin = 1'($urandom);
            if (seen) break;
        end
        start = 1'b0;
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int bc;
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int bc;
        logic [W-1:0] ra, rb;
        // Reset state, with start asserted to show it is ignored under reset.
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        #1;
        start = 1'b0;
        rst_n = 1'b1;

        start_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
        wait_done(-1, bc);
        check("busy_cycles", 32'(bc), 32'(STEPS));
        check("v1_sum", 32'(sum), 32'h96);
        check("v1_cout", 32'(cout), 32'd0);
        check("v1_ovf", 32'(ovf), 32'd1);

        start_op(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0);
        wait_done(-1, bc);
        check("v2_sum", 32'(sum), 32'h01);
        check("v2_cout", 32'(cout), 32'd1);
        check("v2_ovf", 32'(ovf), 32'd0);

        start_op(8'h10, 8'h20, 1'b1, 1'b1, 1'b0);
        wait_done(-1, bc);
        check("v3_sum", 32'(sum), 32'hF0);
        check("v3_cout", 32'(cout), 32'd0);
        check("v3_ovf", 32'(ovf), 32'd0);

        start_op(8'h80, 8'h01, 1'b1, 1'b0, 1'b0);
        wait_done(-1, bc);
        check("v4_sum", 32'(sum), 32'h7F);
        check("v4_cout", 32'(cout), 32'd1);
        check("v4_ovf", 32'(ovf), 32'd1);

        // Start re-pulsed at RUN step 1 must be ignored.
        start_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
        wait_done(1, bc);
        check("ignored_start_busy", 32'(bc), 32'(STEPS));
        repeat (3) @(negedge clk);
        check("ignored_start_idle", 32'(busy), 32'd0);

        // Reset at RUN step 2 aborts with no done and no partial result.
        start_op(8'h33, 8'h44, 1'b0, 1'b1, 1'b0);
        @(negedge clk); #1; start = 1'b0;
        @(negedge clk); #1;
        @(negedge clk); #1; rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        #1; rst_n = 1'b1;
        repeat (6) @(negedge clk);
        start_op(8'h21, 8'h43, 1'b1, 1'b0, 1'b0);
        wait_done(-1, bc);

        // Back-to-back: start held in DONE.
        start_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
        wait_done(-1, bc);
        start_op(8'hC3, 8'h5A, 1'b1, 1'b1, 1'b1);
        wait_done(-1, bc);
        check("b2b_busy", 32'(bc), 32'(STEPS));

        // Randomized operations, some chained back-to-back.
        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (n % 8 == 0) rb = ra;
            start_op(ra, rb, 1'($urandom), 1'($urandom), (n > 0) && ($urandom_range(0, 1) == 1));
            wait_done(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1, bc);
        end

        repeat (8) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 SHALL have parameter DIGIT, default 2, giving the bits processed per cycle; WIDTH % DIGIT == 0 and DIGIT >= 1 are legal, all other values are illegal and SHALL be rejected at elaboration.
REQ-003 SHALL derive STEPS = WIDTH/DIGIT internally.
REQ-004 clk  in  1  single clock, all state changes on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  request to begin an operation.
REQ-007 sub  in  1  0 = add, 1 = subtract (a - b).
REQ-008 cin  in  1  carry-in, used for add only.
REQ-009 a  in  WIDTH  operand A.
REQ-010 b  in  WIDTH  operand B.
REQ-011 busy  out  1  operation in progress.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 sum  out  WIDTH  registered result.
REQ-014 cout  out  1  final carry-out (for subtract, 1 = no borrow).
REQ-015 ovf  out  1  signed two's-complement overflow.

Function
REQ-016 SHALL implement states IDLE, RUN and DONE.
REQ-017 SHALL accept start only in IDLE or DONE; start in RUN SHALL be ignored with no effect.
REQ-018 On the accept edge SHALL:
  - capture a and b, with b bitwise inverted when sub=1;
  - initialise the carry register to cin when sub=0, or to 1 when sub=1 (cin ignored);
  - clear the step counter;
  - move to RUN.
REQ-019 In RUN, each edge SHALL add one DIGIT-bit slice, LSB slice first, plus the carry register; it SHALL store the slice sum and update the carry register.
REQ-020 The step counter SHALL run from 0 to STEPS-1; the edge that processes slice STEPS-1 SHALL move the state to DONE.
REQ-021 sum, cout and ovf SHALL update only on that final edge and SHALL hold until the next completion or reset; the partial result SHALL never appear on sum.
REQ-022 ovf SHALL equal (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
REQ-023 done SHALL be high for exactly the one cycle spent in DONE, which is STEPS edges after the accept edge.
REQ-024 busy SHALL be high exactly while in RUN.
REQ-025 DONE SHALL go to IDLE next edge, or to RUN if start=1 in DONE, giving back-to-back throughput of one result per STEPS+1 cycles.
REQ-026 With DIGIT == WIDTH, STEPS=1: done SHALL rise one edge after accept.
REQ-027 Changes on a, b, sub or cin after the accept edge SHALL NOT affect the operation in progress.

Reset
REQ-028 On a clock edge with rst_n=0 SHALL:
  - enter IDLE;
  - set busy=0, done=0, sum=0, cout=0, ovf=0;
  - clear the carry register and step counter.
REQ-029 Reset in RUN SHALL abort the operation, produce no done pulse and leave no partial result on sum.
REQ-030 start sampled while rst_n=0 SHALL be ignored.

Verification (WIDTH=8, DIGIT=2, STEPS=4)
REQ-031 Add, a=0x5A, b=0x3C, cin=0, sub=0 -> sum=0x96, cout=0, ovf=1; busy high for 4 cycles; done pulses 4 edges after accept.
REQ-032 Add with carry-in, a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1, ovf=0.
REQ-033 Subtract:
  - a=0x10, b=0x20, sub=1 -> sum=0xF0, cout=0, ovf=0;
  - a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
REQ-034 Pulse start again at RUN step 1 with different operands -> ignored; the first result completes unchanged; operand changes mid-RUN have no effect.
REQ-035 Assert rst_n=0 at RUN step 2 -> next cycle busy=0, sum=0x00, cout=0, ovf=0; no done pulse; the next start completes normally.
REQ-036 Hold start=1 during DONE with new operands -> RUN entered immediately with no IDLE cycle; second done pulse 5 cycles after the first; the first result is held until then.
